wb_register_file: RTL
=====================

// Module: wb_register_file
// PURPOSE
//  Receiving end of the write-back interface: architectural register file for the MIPS 5-stage pipeline.
//  Commits wb_data from the write-back stage and serves two combinational read ports to decode (rs/rt).
//  Owns the halt sequence: a halt seen at write-back blocks further commits, drains, then reports halted.
//  The bench ends simulation when halted is set; $finish is not used here.
//  Also keeps a retired-write counter for the bench.
// PARAMETERS
//  DATA         32  register / data width (from TYPES package)
//  REGS         32  number of architectural registers
//  AW            5  register address width, $clog2(REGS)
//  DRAIN_CYCLES  2  cycles spent in DRAIN before HALTED (legal 1..15)
// PORTS
//  clk          in   1     single clock; every state update is on its rising edge
//  rst_n        in   1     asynchronous, active-low reset
//  wb_en        in   1     write-back valid (regWrite of the WB-stage instruction)
//  wb_addr      in   AW    destination register
//  wb_data      in   DATA  value from write-back mux
//  halt_signal  in   1     WB-stage instruction is HALT
//  rs_addr      in   AW    decode read port A address
//  rt_addr      in   AW    decode read port B address
//  rs_data      out  DATA  read port A data
//  rt_data      out  DATA  read port B data
//  retire_cnt   out  32    count of committed writes, saturating
//  halted       out  1     halt sequence complete
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset (rst_n=0, async): all regs=0, state=RUN, drain_cnt=0, retire_cnt=0, halted=0.
//  Reset mid-DRAIN or in HALTED returns to RUN immediately.
//  FSM: RUN -> DRAIN when halt_signal=1.
//    DRAIN: drain_cnt counts 0..DRAIN_CYCLES-1, then -> HALTED.
//    HALTED is terminal until reset.
//    halt_signal is ignored in DRAIN and HALTED.
//  Commit: in RUN, wb_en=1 and wb_addr!=0 -> regs[wb_addr]<=wb_data on the edge; retire_cnt+1.
//    wb_en=1 with wb_addr==0: no write; still counts as retired.
//    retire_cnt holds at 32'hFFFF_FFFF.
//    Same-cycle wb_en and halt_signal in RUN: the write commits and counts.
//      It commits on the same edge that enters DRAIN.
//    In DRAIN/HALTED: wb_en is ignored; no write, no count.
//  Reads: combinational. Address 0 always returns 0.
//    Otherwise returns regs[addr], or the bypass value (see CONFIGURATION).
//  halted: registered; 1 exactly when state==HALTED; rises DRAIN_CYCLES+1 edges after halt is sampled.
// CONFIGURATION
//  Macro: REGFILE_BYPASS_EN
//  Defined: a read whose address matches a same-cycle commit returns wb_data that cycle.
//    A same-cycle commit means state==RUN, wb_en=1, wb_addr==addr, addr!=0.
//  Undefined: reads return the stored value only.
//    A new value is visible one cycle after its commit edge; decode must cover the gap (stall or forwarding).
// STRUCTURE
//  TYPES package adds:
//    rf_state_t enum {RUN, DRAIN, HALTED}
//    localparams REGS, AW, DRAIN_CYCLES
//  DATA is already provided by TYPES.
//  One sub-module: rf_read_port, instantiated twice. It holds the addr==0 zeroing and the optional bypass mux.
//  Storage, FSM and counter live in the top module.
// TESTING
//  Reset value: hold rst_n=0 with random wb_en/addr/data.
//    -> all reads 0, retire_cnt=0, halted=0.
//    Deassert, then read all 32 addrs -> all 0.
//  Write/read: wb_en=1, wb_addr=5, wb_data=32'hDEAD_BEEF.
//    -> rs_addr=5 returns DEAD_BEEF next cycle; retire_cnt=1.
//  R0 protection: write 32'h1234 to addr 0 -> rs_addr=0 reads 0; retire_cnt increments.
//  Bypass: same cycle wb_en=1, addr=7, data=32'hA5A5, rt_addr=7.
//    -> rt_data=A5A5 with REGFILE_BYPASS_EN; old value (0) without it.
//  Halt: wb_en=1, addr=3, data=9 with halt_signal=1 in the same cycle.
//    -> reg3=9; halted rises on the 3rd edge (DRAIN_CYCLES=2).
//    Writes to addr 4 during DRAIN are dropped; retire_cnt is frozen.
//  Reset mid-DRAIN: assert rst_n=0 one cycle after halt.
//    -> halted stays 0, state RUN, regs cleared; writes accepted after release.

Source files
------------

// File: rtl/wb_register_file_pkg.sv
// Shared types and sizing for the write-back register file.
// Optional build macro used by this block: REGFILE_BYPASS_EN.
package wb_register_file_pkg;
    localparam int DATA         = 32;
    localparam int REGS         = 32;
    localparam int AW           = $clog2(REGS);
    localparam int DRAIN_CYCLES = 2;   // legal 1..15
    localparam int CNT_W        = 4;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } rf_state_t;
endpackage

// File: rtl/wb_register_file_read_port.sv
// One combinational decode read port: register 0 reads as zero.
// With REGFILE_BYPASS_EN defined, a same-cycle commit to the read address is forwarded.
module rf_read_port
    import wb_register_file_pkg::*;
(
    input  logic [AW-1:0]              addr,
    input  logic [REGS-1:0][DATA-1:0]  regs,
`ifdef REGFILE_BYPASS_EN
    input  logic                       commit,
    input  logic [AW-1:0]              commit_addr,
    input  logic [DATA-1:0]            commit_data,
`endif
    output logic [DATA-1:0]            data
);

    always_comb begin
        data = '0;
        if (addr != '0) begin
            data = regs[addr];
`ifdef REGFILE_BYPASS_EN
            if (commit && (commit_addr == addr))
                data = commit_data;
`endif
        end
    end

endmodule

// File: rtl/wb_register_file.sv
// Architectural register file at the write-back end of the pipeline: commit, reads, halt drain, retire count.
// Build option REGFILE_BYPASS_EN forwards same-cycle commits to the read ports.
module wb_register_file
    import wb_register_file_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [DATA-1:0] wb_data,
    input  logic            halt_signal,
    input  logic [AW-1:0]   rs_addr,
    input  logic [AW-1:0]   rt_addr,
    output logic [DATA-1:0] rs_data,
    output logic [DATA-1:0] rt_data,
    output logic [31:0]     retire_cnt,
    output logic            halted
);

    logic [REGS-1:0][DATA-1:0] regs;
    rf_state_t                 state, state_next;
    logic [CNT_W-1:0]          drain_cnt, drain_next;
    logic                      commit, write;

    // Commits are only honoured in RUN, including the edge that enters DRAIN.
    assign commit = (state == RUN) && wb_en;
    assign write  = commit && (wb_addr != '0);

    always_comb begin
        state_next = state;
        drain_next = drain_cnt;
        case (state)
            RUN: begin
                if (halt_signal) begin
                    state_next = DRAIN;
                    drain_next = '0;
                end
            end
            DRAIN: begin
                if (drain_cnt == CNT_W'(DRAIN_CYCLES - 1))
                    state_next = HALTED;
                else
                    drain_next = drain_cnt + CNT_W'(1);
            end
            HALTED: ;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= '0;
            halted    <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_next;
            halted    <= (state_next == HALTED);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retire_cnt <= '0;
        else if (commit && (retire_cnt != 32'hFFFF_FFFF))
            retire_cnt <= retire_cnt + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            regs <= '0;
        else if (write)
            regs[wb_addr] <= wb_data;
    end

    rf_read_port u_rs (
        .addr        (rs_addr),
        .regs        (regs),
`ifdef REGFILE_BYPASS_EN
        .commit      (commit),
        .commit_addr (wb_addr),
        .commit_data (wb_data),
`endif
        .data        (rs_data)
    );

    rf_read_port u_rt (
        .addr        (rt_addr),
        .regs        (regs),
`ifdef REGFILE_BYPASS_EN
        .commit      (commit),
        .commit_addr (wb_addr),
        .commit_data (wb_data),
`endif
        .data        (rt_data)
    );

endmodule
